// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the register-file write port between WB and an in-order multi-cycle result FIFO
// Optional forced-drain starvation guard: `define STARVE_GUARD_EN
module regfile_write_arbiter #(
    parameter  int DATA_W       = 32,
    parameter  int ADDR_W       = 5,
    parameter  int FIFO_DEPTH   = 4,
    parameter  int STARVE_LIMIT = 8,
    localparam int PTR_W        = $clog2(FIFO_DEPTH),
    localparam int CNT_W        = PTR_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wb_valid_i,
    input  logic [ADDR_W-1:0] wb_reg_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic              mc_valid_i,
    output logic              mc_ready_o,
    input  logic [ADDR_W-1:0] mc_reg_i,
    input  logic [DATA_W-1:0] mc_data_i,
    output logic              wb_stall_o,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    output logic [31:0]       pend_mask_o,
    output logic [CNT_W-1:0]  pend_count_o
);

    logic [ADDR_W-1:0]     reg_q  [FIFO_DEPTH];
    logic [DATA_W-1:0]     data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] live_q, live_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]     rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]     rf_wdata_q, rf_wdata_d;
    logic                  full, head_valid, head_live, force_drain;
    logic                  wb_grant, fifo_grant, push, pop;

    assign full       = (count_q == CNT_W'(FIFO_DEPTH));
    assign head_valid = (count_q != '0);
    assign head_live  = head_valid && live_q[rd_ptr_q];

`ifdef STARVE_GUARD_EN
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    logic [SC_W-1:0] starve_q, starve_d;

    assign force_drain = head_live && (starve_q == SC_W'(STARVE_LIMIT));

    always_comb begin
        starve_d = starve_q;
        if (fifo_grant || !head_valid) begin
            starve_d = '0;
        end else if (wb_grant && head_live) begin
            starve_d = starve_q + SC_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) starve_q <= '0;
        else         starve_q <= starve_d;
    end
`else
    assign force_drain = 1'b0;
`endif

    assign wb_stall_o = force_drain;
    assign mc_ready_o = !full;
    assign wb_grant   = wb_valid_i && (wb_reg_i != '0) && !force_drain;
    assign fifo_grant = !wb_grant && head_live;
    // A killed head is discarded even while WB owns the port.
    assign pop        = fifo_grant || (head_valid && !live_q[rd_ptr_q]);
    // Reg-0 results are accepted from the unit but never stored.
    assign push       = mc_valid_i && !full && (mc_reg_i != '0);

    always_comb begin
        live_d = live_q;
        if (wb_grant) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (reg_q[i] == wb_reg_i) live_d[i] = 1'b0;
            end
        end
        if (pop)  live_d[rd_ptr_q] = 1'b0;
        if (push) live_d[wr_ptr_q] = 1'b1;

        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

        rf_we_d    = wb_grant || fifo_grant;
        rf_waddr_d = '0;
        rf_wdata_d = '0;
        if (wb_grant) begin
            rf_waddr_d = wb_reg_i;
            rf_wdata_d = wb_data_i;
        end else if (fifo_grant) begin
            rf_waddr_d = reg_q[rd_ptr_q];
            rf_wdata_d = data_q[rd_ptr_q];
        end
    end

    always_comb begin
        pend_mask_o = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (live_q[i]) pend_mask_o[reg_q[i]] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            live_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            live_q     <= live_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // Payload storage needs no reset; live_q qualifies every slot.
    always_ff @(posedge clk_i) begin
        if (push) begin
            reg_q[wr_ptr_q]  <= mc_reg_i;
            data_q[wr_ptr_q] <= mc_data_i;
        end
    end

    assign rf_we_o      = rf_we_q;
    assign rf_waddr_o   = rf_waddr_q;
    assign rf_wdata_o   = rf_wdata_q;
    assign pend_count_o = count_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
// Covers STARVE_GUARD_EN when that macro is defined for the build.
module tb_regfile_write_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;
`ifdef STARVE_GUARD_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid, mc_valid, mc_ready, wb_stall, rf_we;
    logic [4:0]  wb_reg, mc_reg, rf_waddr;
    logic [31:0] wb_data, mc_data, rf_wdata, pend_mask;
    logic [2:0]  pend_count;

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .wb_valid_i(wb_valid), .wb_reg_i(wb_reg), .wb_data_i(wb_data),
        .mc_valid_i(mc_valid), .mc_ready_o(mc_ready), .mc_reg_i(mc_reg), .mc_data_i(mc_data),
        .wb_stall_o(wb_stall), .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
        .pend_mask_o(pend_mask), .pend_count_o(pend_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        bit          live;
    } ent_t;

    ent_t        mq[$];
    int          m_starve;
    logic        m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;

    task automatic step(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                        input logic mv, input logic [4:0] mr, input logic [31:0] md);
        bit          full, hl, frc, wtake, popf;
        logic [31:0] mask;
        ent_t        e;
        wb_valid = wv; wb_reg = wr; wb_data = wd;
        mc_valid = mv; mc_reg = mr; mc_data = md;
        #1;
        full = (mq.size() == DEPTH);
        hl   = (mq.size() > 0) && mq[0].live;
        frc  = STARVE_ON && (m_starve == LIMIT) && hl;
        mask = '0;
        foreach (mq[i]) if (mq[i].live) mask |= (32'd1 << mq[i].r);
        chk("mc_ready", 64'(mc_ready), 64'(!full));
        chk("pend_mask", 64'(pend_mask), 64'(mask));
        chk("pend_count", 64'(pend_count), 64'(mq.size()));
        chk("wb_stall", 64'(wb_stall), 64'(frc));

        wtake = wv && (wr != 0) && !frc;
        popf  = (mq.size() > 0) && !mq[0].live;
        m_we = 1'b0; m_wa = '0; m_wd = '0;
        if (wtake) begin
            m_we = 1'b1; m_wa = wr; m_wd = wd;
        end else if (hl) begin
            m_we = 1'b1; m_wa = mq[0].r; m_wd = mq[0].d; popf = 1'b1;
        end
        if (frc || (!wtake && hl) || mq.size() == 0) m_starve = 0;
        else if (wtake && hl)                        m_starve++;
        if (wtake) foreach (mq[i]) if (mq[i].r == wr) mq[i].live = 1'b0;
        if (popf) void'(mq.pop_front());
        if (mv && !full && mr != 0) begin
            e.r = mr; e.d = md; e.live = 1'b1;
            mq.push_back(e);
        end

        @(posedge clk); #1;
        chk("rf_we", 64'(rf_we), 64'(m_we));
        chk("rf_waddr", 64'(rf_waddr), 64'(m_wa));
        chk("rf_wdata", 64'(rf_wdata), 64'(m_wd));
    endtask

    typedef struct {
        logic        wv; logic [4:0] wr; logic [31:0] wd;
        logic        mv; logic [4:0] mr; logic [31:0] md;
        logic        we; logic [4:0] wa; logic [31:0] wdx;
        logic        rdy; logic [2:0] cnt; logic [31:0] mask;
    } vec_t;

    vec_t tbl[21];

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rf_we"}, 64'(rf_we), 64'(0));
        chk({tag, "_rf_waddr"}, 64'(rf_waddr), 64'(0));
        chk({tag, "_rf_wdata"}, 64'(rf_wdata), 64'(0));
        chk({tag, "_pend_mask"}, 64'(pend_mask), 64'(0));
        chk({tag, "_pend_count"}, 64'(pend_count), 64'(0));
        chk({tag, "_wb_stall"}, 64'(wb_stall), 64'(0));
        chk({tag, "_mc_ready"}, 64'(mc_ready), 64'(1));
    endtask

    initial begin
        //          wv  wr  wd            mv  mr  md           we  wa  wdata          rdy cnt mask
        tbl[0]  = '{1, 5, 32'hDEAD, 0, 0, 32'h0,  1, 5, 32'hDEAD, 1, 0, 32'h0};
        tbl[1]  = '{0, 0, 32'h0,    0, 0, 32'h0,  0, 0, 32'h0,    1, 0, 32'h0};
        tbl[2]  = '{1, 1, 32'h11,   1, 8, 32'h80, 1, 1, 32'h11,   1, 1, 32'h100};
        tbl[3]  = '{1, 2, 32'h22,   1, 9, 32'h90, 1, 2, 32'h22,   1, 2, 32'h300};
        tbl[4]  = '{1, 3, 32'h33,   1, 10, 32'hA0, 1, 3, 32'h33,  1, 3, 32'h700};
        tbl[5]  = '{1, 4, 32'h44,   1, 11, 32'hB0, 1, 4, 32'h44,  0, 4, 32'hF00};
        tbl[6]  = '{1, 6, 32'h66,   1, 12, 32'hC0, 1, 6, 32'h66,  0, 4, 32'hF00};
        tbl[7]  = '{0, 0, 32'h0,    0, 0, 32'h0,  1, 8, 32'h80,   1, 3, 32'hE00};
        tbl[8]  = '{0, 0, 32'h0,    0, 0, 32'h0,  1, 9, 32'h90,   1, 2, 32'hC00};
        tbl[9]  = '{0, 0, 32'h0,    0, 0, 32'h0,  1, 10, 32'hA0,  1, 1, 32'h800};
        tbl[10] = '{0, 0, 32'h0,    0, 0, 32'h0,  1, 11, 32'hB0,  1, 0, 32'h0};
        tbl[11] = '{0, 0, 32'h0,    1, 7, 32'h1,  0, 0, 32'h0,    1, 1, 32'h80};
        tbl[12] = '{1, 7, 32'h2,    0, 0, 32'h0,  1, 7, 32'h2,    1, 1, 32'h0};
        tbl[13] = '{0, 0, 32'h0,    0, 0, 32'h0,  0, 0, 32'h0,    1, 0, 32'h0};
        tbl[14] = '{1, 0, 32'hFFFF, 1, 0, 32'hFFFF, 0, 0, 32'h0,  1, 0, 32'h0};
        tbl[15] = '{0, 0, 32'h0,    0, 0, 32'h0,  0, 0, 32'h0,    1, 0, 32'h0};
        tbl[16] = '{0, 0, 32'h0,    1, 13, 32'hD0, 0, 0, 32'h0,   1, 1, 32'h2000};
        tbl[17] = '{0, 0, 32'h0,    1, 14, 32'hE0, 1, 13, 32'hD0, 1, 1, 32'h4000};
        tbl[18] = '{0, 0, 32'h0,    0, 0, 32'h0,  1, 14, 32'hE0,  1, 0, 32'h0};
        tbl[19] = '{1, 15, 32'h1,   1, 15, 32'h2, 1, 15, 32'h1,   1, 1, 32'h8000};
        tbl[20] = '{0, 0, 32'h0,    0, 0, 32'h0,  1, 15, 32'h2,   1, 0, 32'h0};

        rst_n = 1'b0;
        wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
        mc_valid = 1'b0; mc_reg = '0; mc_data = '0;
        m_starve = 0;
        #12;
        chk_reset_outputs("init");
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].wv, tbl[i].wr, tbl[i].wd, tbl[i].mv, tbl[i].mr, tbl[i].md);
            chk($sformatf("t%0d_we", i), 64'(rf_we), 64'(tbl[i].we));
            chk($sformatf("t%0d_waddr", i), 64'(rf_waddr), 64'(tbl[i].wa));
            chk($sformatf("t%0d_wdata", i), 64'(rf_wdata), 64'(tbl[i].wdx));
            chk($sformatf("t%0d_ready", i), 64'(mc_ready), 64'(tbl[i].rdy));
            chk($sformatf("t%0d_count", i), 64'(pend_count), 64'(tbl[i].cnt));
            chk($sformatf("t%0d_mask", i), 64'(pend_mask), 64'(tbl[i].mask));
        end

        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            if (rf_we && rf_waddr == 5'd0) chk("rand_no_reg0_write", 64'(rf_waddr), 64'(1));
        end

        step(1'b1, 5'd1, 32'h5, 1'b1, 5'd20, 32'h20);
        step(1'b1, 5'd2, 32'h6, 1'b1, 5'd21, 32'h21);
        wb_valid = 1'b1; wb_reg = 5'd9; wb_data = 32'h99;
        mc_valid = 1'b1; mc_reg = 5'd22; mc_data = 32'h22;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk); #1;
        wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
        mc_valid = 1'b0; mc_reg = '0; mc_data = '0;
        rst_n = 1'b1;
        mq.delete();
        m_starve = 0;
        #1;
        chk("post_rst_mc_ready", 64'(mc_ready), 64'(1));
        chk("post_rst_pend_count", 64'(pend_count), 64'(0));
        @(posedge clk); #1;
        chk("post_rst_rf_we", 64'(rf_we), 64'(0));
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h44);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("post_rst_drain", 64'(rf_waddr), 64'(4));

`ifdef STARVE_GUARD_EN
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h33);
        for (int k = 0; k < LIMIT; k++) begin
            step(1'b1, 5'd1, 32'(k), 1'b0, 5'd0, 32'h0);
            chk($sformatf("starve_wb%0d", k), 64'(rf_waddr), 64'(1));
        end
        wb_valid = 1'b1; wb_reg = 5'd1; wb_data = 32'h8;
        mc_valid = 1'b0; mc_reg = '0; mc_data = '0;
        #1;
        chk("starve_stall", 64'(wb_stall), 64'(1));
        step(1'b1, 5'd1, 32'h8, 1'b0, 5'd0, 32'h0);
        chk("starve_forced_addr", 64'(rf_waddr), 64'(3));
        chk("starve_forced_data", 64'(rf_wdata), 64'(32'h33));
        step(1'b1, 5'd1, 32'h8, 1'b0, 5'd0, 32'h0);
        chk("starve_held_wb", 64'(rf_waddr), 64'(1));
        chk("starve_stall_gone", 64'(wb_stall), 64'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
